// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator tile movers (input loader and
// output write-back): write-back FSM states and the element legality test.
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_LAST,
    WB_DONE
  } wb_state_t;

  // An element is legal when its absolute coordinates lie inside the feature map.
  function automatic logic elem_legal(
    input logic [63:0] n,
    input logic [63:0] row,
    input logic [63:0] col,
    input logic [63:0] n_lim,
    input logic [63:0] row_lim,
    input logic [63:0] col_lim
  );
    return (n < n_lim) && (row < row_lim) && (col < col_lim);
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Walks a Tn x Tr x Tc tile (tc fastest, then tr, then tn) from a latched
// origin and produces the row-major address, legality and last-element flags.
module tile_addr_gen
  import cnn_accel_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 32,
  parameter int N  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 8,
  parameter int Tr = 16,
  parameter int Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [CW-1:0] base_n,
  input  logic [CW-1:0] base_row,
  input  logic [CW-1:0] base_col,
  output logic [AW-1:0] addr,
  output logic          legal,
  output logic          last
);

  logic [CW-1:0] base_n_q, base_row_q, base_col_q;
  logic [CW-1:0] tn, tr, tc;
  logic [CW-1:0] abs_n, abs_row, abs_col, lin_addr;
  logic          tc_wrap, tr_wrap, tn_wrap;

  assign tc_wrap = (tc == CW'(Tc - 1));
  assign tr_wrap = (tr == CW'(Tr - 1));
  assign tn_wrap = (tn == CW'(Tn - 1));

  // A load restarts the walk at the new origin; counters only move on adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_n_q   <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
      tn         <= '0;
      tr         <= '0;
      tc         <= '0;
    end else if (load) begin
      base_n_q   <= base_n;
      base_row_q <= base_row;
      base_col_q <= base_col;
      tn         <= '0;
      tr         <= '0;
      tc         <= '0;
    end else if (adv) begin
      tc <= tc_wrap ? '0 : tc + CW'(1);
      if (tc_wrap) begin
        tr <= tr_wrap ? '0 : tr + CW'(1);
        if (tr_wrap) begin
          tn <= tn_wrap ? '0 : tn + CW'(1);
        end
      end
    end
  end

  assign abs_n    = base_n_q + tn;
  assign abs_row  = base_row_q + tr;
  assign abs_col  = base_col_q + tc;
  assign lin_addr = abs_n * CW'(R * C) + abs_row * CW'(C) + abs_col;
  assign addr     = AW'(lin_addr);

  assign legal = elem_legal(64'(abs_n), 64'(abs_row), 64'(abs_col),
                            64'(N), 64'(R), 64'(C));
  assign last  = tc_wrap && tr_wrap && tn_wrap;

endmodule

// File: rtl/out_fm_fifo_to_ram.sv
// Drains one output tile from the conv core FIFO into the row-major output RAM,
// popping every element but writing only those that fall inside the map.
module out_fm_fifo_to_ram
  import cnn_accel_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int N  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 8,
  parameter int Tr = 16,
  parameter int Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          fifo_pop,
  input  logic          fifo_empty,
  input  logic [DW-1:0] data_from_fifo,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] data_to_ram,
  input  logic [CW-1:0] tile_base_n,
  input  logic [CW-1:0] tile_base_row,
  input  logic [CW-1:0] tile_base_col
);

  wb_state_t     state;
  logic          load, pop, gen_legal, gen_last, pipe_valid;
  logic [AW-1:0] gen_addr;

  assign load     = (state == WB_IDLE) && start;
  assign pop      = (state == WB_RUN) && !fifo_empty;
  assign fifo_pop = pop;

  tile_addr_gen #(
    .CW(CW), .AW(AW), .N(N), .R(R), .C(C), .Tn(Tn), .Tr(Tr), .Tc(Tc)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .adv      (pop),
    .base_n   (tile_base_n),
    .base_row (tile_base_row),
    .base_col (tile_base_col),
    .addr     (gen_addr),
    .legal    (gen_legal),
    .last     (gen_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WB_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        WB_IDLE: if (start) state <= WB_RUN;
        WB_RUN:  if (pop && gen_last) state <= WB_LAST;
        WB_LAST: begin
          state <= WB_DONE;
          done  <= 1'b1;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // The popped word arrives one cycle later, so address and legality ride one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      ram_wena   <= 1'b0;
      ram_addr   <= '0;
    end else begin
      pipe_valid <= pop;
      ram_wena   <= pop && gen_legal;
      if (pop) ram_addr <= gen_addr;
    end
  end

  assign data_to_ram = pipe_valid ? data_from_fifo : '0;

endmodule
